// File: rtl/cs_fifoc2cmd_if.sv
// Handshake bundle between the sequencer/FIFO side and cs_fifoc2cmd.
// master: sequencer + FIFO (drives fs, empty, dout); slave: cs_fifoc2cmd.
interface cs_fifoc2cmd_if;
  logic       fs_fifoc2cs;
  logic       fd_fifoc2cs;
  logic       fifoc_empty;
  logic [7:0] fifoc_dout;
  logic       fifoc_rd_en;
  logic [7:0] cmd_kdev;
  logic [7:0] cmd_smpr;
  logic [7:0] cmd_filt;
  logic [7:0] cmd_mix0;
  logic [7:0] cmd_mix1;
  logic [7:0] cmd_reg4;
  logic [7:0] cmd_reg5;
  logic [7:0] cmd_reg6;
  logic [7:0] cmd_reg7;
  logic       err;

  modport master (
    output fs_fifoc2cs, fifoc_empty, fifoc_dout,
    input  fd_fifoc2cs, fifoc_rd_en,
    input  cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1,
    input  cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7, err
  );

  modport slave (
    input  fs_fifoc2cs, fifoc_empty, fifoc_dout,
    output fd_fifoc2cs, fifoc_rd_en,
    output cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1,
    output cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7, err
  );
endinterface

// File: rtl/cs_fifoc2cmd.sv
// Pops one command frame (HEAD0 HEAD1 + 9 body bytes [+ XOR checksum]) from
// FIFO "fifoc" on fs_fifoc2cs, then commits the nine cmd_* bytes atomically.
// Ports: clk, rst (async, active high), io (cs_fifoc2cmd_if.slave):
//   fs_fifoc2cs/fd_fifoc2cs start/done levels, fifoc_* FWFT FIFO read side,
//   cmd_* committed command bytes, err sticky frame error.
// Optional feature: define CS_CMD_CHKSUM_EN to add the checksum byte/state.
module cs_fifoc2cmd #(
  parameter logic [7:0]  HEAD0   = 8'h55,
  parameter logic [7:0]  HEAD1   = 8'hAA,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input logic           clk,
  input logic           rst,
  cs_fifoc2cmd_if.slave io
);

`ifdef CS_CMD_CHKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HEAD0, S_HEAD1, S_BODY, S_CHKS, S_COMMIT, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HEAD0, S_HEAD1, S_BODY, S_COMMIT, S_DONE
  } state_t;
`endif

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [7:0]  shadow_q [9];
  logic [7:0]  cmd_q [9];
  logic [15:0] timer_q;
  logic        fd_q;
  logic        err_q;
`ifdef CS_CMD_CHKSUM_EN
  logic [7:0]  chk_q;
`endif

  logic        active;
  logic        take;
  logic [7:0]  byte_i;
  logic [15:0] timer_d;

  // States that read the FIFO.
  always_comb begin
    active = 1'b0;
    unique case (state_q)
      S_HEAD0, S_HEAD1, S_BODY: active = 1'b1;
`ifdef CS_CMD_CHKSUM_EN
      S_CHKS: active = 1'b1;
`endif
      default: active = 1'b0;
    endcase
  end

  assign take    = active && !io.fifoc_empty;
  assign byte_i  = io.fifoc_dout;
  assign timer_d = timer_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef CS_CMD_CHKSUM_EN
      chk_q   <= '0;
`endif
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= '0;
        cmd_q[i]    <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (io.fs_fifoc2cs) begin
            state_q <= S_HEAD0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            timer_q <= '0;
`ifdef CS_CMD_CHKSUM_EN
            chk_q   <= '0;
`endif
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < 9; i++)
            cmd_q[i] <= shadow_q[i];
          state_q <= S_DONE;
          fd_q    <= 1'b1;
        end
        S_DONE: begin
          if (!io.fs_fifoc2cs) begin
            state_q <= S_IDLE;
            fd_q    <= 1'b0;
          end
        end
        default: begin
          // Frame reception; losing fs wins over everything.
          if (!io.fs_fifoc2cs) begin
            state_q <= S_IDLE;
          end else if (take) begin
            timer_q <= '0;
            if (state_q == S_HEAD0) begin
              if (byte_i == HEAD0)
                state_q <= S_HEAD1;
            end else if (state_q == S_HEAD1) begin
              // A repeated HEAD0 may still start a valid frame.
              if (byte_i == HEAD1)
                state_q <= S_BODY;
              else if (byte_i != HEAD0)
                state_q <= S_HEAD0;
            end else if (state_q == S_BODY) begin
              shadow_q[idx_q] <= byte_i;
              idx_q <= idx_q + 4'd1;
`ifdef CS_CMD_CHKSUM_EN
              chk_q <= chk_q ^ byte_i;
              if (idx_q == 4'd8)
                state_q <= S_CHKS;
`else
              if (idx_q == 4'd8)
                state_q <= S_COMMIT;
`endif
            end
`ifdef CS_CMD_CHKSUM_EN
            else begin
              if (byte_i == chk_q) begin
                state_q <= S_COMMIT;
              end else begin
                err_q   <= 1'b1;
                fd_q    <= 1'b1;
                state_q <= S_DONE;
              end
            end
`endif
          end else if (timer_d == TIMEOUT - 16'd1) begin
            timer_q <= timer_d;
            err_q   <= 1'b1;
            fd_q    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            timer_q <= timer_d;
          end
        end
      endcase
    end
  end

  assign io.fifoc_rd_en = take;
  assign io.fd_fifoc2cs = fd_q;
  assign io.err         = err_q;
  assign io.cmd_kdev    = cmd_q[0];
  assign io.cmd_smpr    = cmd_q[1];
  assign io.cmd_filt    = cmd_q[2];
  assign io.cmd_mix0    = cmd_q[3];
  assign io.cmd_mix1    = cmd_q[4];
  assign io.cmd_reg4    = cmd_q[5];
  assign io.cmd_reg5    = cmd_q[6];
  assign io.cmd_reg6    = cmd_q[7];
  assign io.cmd_reg7    = cmd_q[8];

endmodule

// File: tb/tb_cs_fifoc2cmd.sv
// Bench for cs_fifoc2cmd: queue-modelled FWFT FIFO, expected-frame
// scoreboard popped by a monitor on each rising fd_fifoc2cs.
module tb_cs_fifoc2cmd;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cs_fifoc2cmd_if io ();

  cs_fifoc2cmd #(.TIMEOUT(16'd16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    logic [71:0] body;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fq[$];
  logic       gate   = 1'b0;
  logic       toggle = 1'b0;
  int         errs   = 0;
  int         checks = 0;

  task automatic upd();
    io.fifoc_empty = (fq.size() == 0) || gate;
    io.fifoc_dout  = (fq.size() == 0) ? 8'h00 : fq[0];
  endtask

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    upd();
  endtask

  task automatic push_frame(input logic [71:0] body);
    logic [7:0] c;
    c = 8'h00;
    push_byte(8'h55);
    push_byte(8'hAA);
    for (int i = 8; i >= 0; i--) begin
      push_byte(body[i*8 +: 8]);
      c = c ^ body[i*8 +: 8];
    end
`ifdef CS_CMD_CHKSUM_EN
    push_byte(c);
`endif
  endtask

  task automatic expect_frame(input logic [71:0] body, input logic e);
    exp_t x;
    x.body = body;
    x.err  = e;
    sb.push_back(x);
  endtask

  // fs high until done, then release and see fd drop.
  task automatic run_frame(input string nm);
    int n;
    io.fs_fifoc2cs = 1'b1;
    n = 0;
    while (io.fd_fifoc2cs !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (io.fd_fifoc2cs !== 1'b1) begin
      checks++;
      errs++;
      $display("FAIL %s_done: got fd=%b want 1 within 300", nm,
               io.fd_fifoc2cs);
    end
    @(posedge clk);
    #1 io.fs_fifoc2cs = 1'b0;
    n = 0;
    while (io.fd_fifoc2cs !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (io.fd_fifoc2cs !== 1'b0) begin
      checks++;
      errs++;
      $display("FAIL %s_release: got fd=%b want 0", nm, io.fd_fifoc2cs);
    end
    @(posedge clk);
    #1;
  endtask

  // FIFO read side: a byte is consumed at the edge closing a cycle whose
  // rd_en was high.
  initial begin
    logic tk;
    upd();
    forever begin
      @(negedge clk);
      tk = io.fifoc_rd_en;
      @(posedge clk);
      #1;
      if (tk && fq.size() > 0)
        void'(fq.pop_front());
      if (toggle)
        gate = ~gate;
      upd();
    end
  end

  // Monitor: compare committed bytes and err on each new done.
  initial begin
    logic  fd_prev;
    exp_t  x;
    string nm[9];
    logic [7:0] act[9];
    nm = '{"kdev", "smpr", "filt", "mix0", "mix1",
           "reg4", "reg5", "reg6", "reg7"};
    fd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (io.fd_fifoc2cs === 1'b1 && fd_prev !== 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_done: got fd=1 want no done");
        end else begin
          x = sb.pop_front();
          act = '{io.cmd_kdev, io.cmd_smpr, io.cmd_filt,
                  io.cmd_mix0, io.cmd_mix1, io.cmd_reg4,
                  io.cmd_reg5, io.cmd_reg6, io.cmd_reg7};
          for (int i = 0; i < 9; i++)
            check({"cmd_", nm[i]}, act[i], x.body[(8-i)*8 +: 8]);
          check("err", {7'd0, io.err}, {7'd0, x.err});
        end
      end
      fd_prev = io.fd_fifoc2cs;
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    io.fs_fifoc2cs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_kdev", io.cmd_kdev, 8'h00);
    check("rst_reg7", io.cmd_reg7, 8'h00);
    check("rst_fd", {7'd0, io.fd_fifoc2cs}, 8'h00);
    check("rst_err", {7'd0, io.err}, 8'h00);
    check("rst_rd_en", {7'd0, io.fifoc_rd_en}, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    push_frame(72'h01_02_03_04_05_06_07_08_09);
    expect_frame(72'h01_02_03_04_05_06_07_08_09, 1'b0);
    run_frame("good");

    push_byte(8'h00);
    push_byte(8'h55);
    push_frame(72'h11_12_13_14_15_16_17_18_19);
    expect_frame(72'h11_12_13_14_15_16_17_18_19, 1'b0);
    run_frame("junk");

`ifdef CS_CMD_CHKSUM_EN
    push_byte(8'h55);
    push_byte(8'hAA);
    for (int i = 1; i <= 9; i++)
      push_byte(8'h20 + 8'(i));
    push_byte(8'h00);
    expect_frame(72'h11_12_13_14_15_16_17_18_19, 1'b1);
    run_frame("badchk");
`endif

    push_byte(8'h55);
    push_byte(8'hAA);
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    expect_frame(72'h11_12_13_14_15_16_17_18_19, 1'b1);
    run_frame("timeout");

    push_byte(8'h55);
    push_byte(8'hAA);
    push_byte(8'h21);
    push_byte(8'h22);
    push_byte(8'h23);
    push_byte(8'h24);
    io.fs_fifoc2cs = 1'b1;
    n = 0;
    while (fq.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (fq.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL abort_drain: got %0d bytes left want 0", fq.size());
    end
    repeat (3) @(posedge clk);
    #1 io.fs_fifoc2cs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_fd", {7'd0, io.fd_fifoc2cs}, 8'h00);
    end
    check("abort_kdev", io.cmd_kdev, 8'h11);
    check("abort_reg7", io.cmd_reg7, 8'h19);
    check("abort_err", {7'd0, io.err}, 8'h00);
    @(posedge clk);
    #1;

    push_frame(72'h31_32_33_34_35_36_37_38_39);
    expect_frame(72'h31_32_33_34_35_36_37_38_39, 1'b0);
    run_frame("after_abort");

    toggle = 1'b1;
    push_frame(72'h41_42_43_44_45_46_47_48_49);
    expect_frame(72'h41_42_43_44_45_46_47_48_49, 1'b0);
    run_frame("stall");
    toggle = 1'b0;
    gate   = 1'b0;
    upd();

    push_frame(72'h51_52_53_54_56_57_58_59_5A);
    io.fs_fifoc2cs = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_kdev", io.cmd_kdev, 8'h00);
    check("arst_reg7", io.cmd_reg7, 8'h00);
    check("arst_fd", {7'd0, io.fd_fifoc2cs}, 8'h00);
    check("arst_rd_en", {7'd0, io.fifoc_rd_en}, 8'h00);
    io.fs_fifoc2cs = 1'b0;
    @(posedge clk);
    #1;
    fq.delete();
    upd();
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sb_left", 8'(sb.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
